tsc_memory_responder: RTL and testbench

TSC_MEMORY_RESPONDER -- requirements
Module: tsc_memory_responder

---
 rtl/tsc_memory_responder_pkg.sv | 14 +
 rtl/tsc_mem_array.sv | 21 ++
 rtl/tsc_memory_responder.sv | 130 +++++++++++++
 tb/tb_tsc_memory_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tsc_memory_responder_pkg.sv
// Shared constants and FSM encoding for the TSC memory responder.
package tsc_memory_responder_pkg;
  localparam int WORD_SIZE_DEF = 16;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DONE = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4,
    HOLD    = 3'd5
  } state_e;
endpackage

// File: rtl/tsc_mem_array.sv
// Single-port word array: synchronous write, asynchronous read, no reset.
module tsc_mem_array #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 256,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [WORD_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/tsc_memory_responder.sv
// Latency-modelling memory slave for the TSC CPU: read/write handshake FSM
// on a shared tri-state data bus, plus a preload port for simulation.
module tsc_memory_responder
  import tsc_memory_responder_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  input  logic                 init_we,
  input  logic [WORD_SIZE-1:0] init_addr,
  input  logic [WORD_SIZE-1:0] init_data,
  output logic                 proto_err
);
  localparam int AW = $clog2(MEM_DEPTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 ready_q, ready_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 init_ok, mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata, rdata;

  // Address bits above the array size are dropped, so requests wrap.
  if (WORD_SIZE > AW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{address[WORD_SIZE-1:AW], init_addr[WORD_SIZE-1:AW]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ready_d = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (readM) begin
          addr_d  = address[AW-1:0];
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = RD_WAIT;
          if (writeM) err_d = 1'b1;
        end else if (writeM) begin
          addr_d  = address[AW-1:0];
          wdata_d = data;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RD_DONE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = WR_DONE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_DONE, WR_DONE: state_d = HOLD;
      // Wait for the CPU to drop its request so a held level cannot retrigger.
      HOLD: if (!readM && !writeM) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Commit happens on the edge leaving WR_DONE; reset forces IDLE and drops it.
  assign init_ok   = (state_q == IDLE) && !readM && !writeM && init_we;
  assign mem_we    = (state_q == WR_DONE) || init_ok;
  assign mem_waddr = (state_q == WR_DONE) ? addr_q  : init_addr[AW-1:0];
  assign mem_wdata = (state_q == WR_DONE) ? wdata_q : init_data;

  tsc_mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addr_q),
    .rdata (rdata)
  );

  assign data       = (state_q == RD_DONE) ? rdata : {WORD_SIZE{1'bz}};
  assign inputReady = ready_q;
  assign ackOutput  = ack_q;
  assign proto_err  = err_q;
endmodule

// File: tb/tb_tsc_memory_responder.sv
// Directed bench for tsc_memory_responder; the bench holds a probe pattern on
// the bus whenever the responder must be high-Z, so any stray drive corrupts it.
module tb_tsc_memory_responder;
  localparam logic [15:0] PROBE = 16'h5A5A;

  logic        clk = 1'b0, reset = 1'b1;
  logic        readM = 1'b0, writeM = 1'b0, init_we = 1'b0;
  logic [15:0] address = '0, init_addr = '0, init_data = '0;
  logic        tb_en = 1'b1;
  logic [15:0] tb_val = PROBE;
  wire  [15:0] data_bus;
  logic        inputReady, ackOutput, proto_err;
  int          checks = 0, errors = 0;
  int          pulses;

  assign data_bus = tb_en ? tb_val : 16'hzzzz;
  always #5 clk = ~clk;

  tsc_memory_responder dut (
    .clk(clk), .reset(reset), .readM(readM), .writeM(writeM),
    .address(address), .data(data_bus), .inputReady(inputReady),
    .ackOutput(ackOutput), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    tick;
    init_we = 1'b0;
  endtask

  // Accept on edge 0; pulse expected while sampled after edge 2, gone after edge 3.
  task automatic read_txn(input string tag, input logic [15:0] a, input logic [15:0] a_after,
                          input logic [15:0] exp, input bit keep);
    readM = 1'b1; address = a;
    tick;
    if (!keep) begin readM = 1'b0; writeM = 1'b0; end
    address = a_after;
    chk({tag, "_c0_rdy"}, inputReady, 0);
    tick;
    chk({tag, "_c1_rdy"}, inputReady, 0);
    chk({tag, "_c1_bus"}, data_bus, PROBE);
    tb_en = 1'b0;
    tick;
    chk({tag, "_c2_rdy"}, inputReady, 1);
    chk({tag, "_c2_data"}, data_bus, exp);
    chk({tag, "_c2_ack"}, ackOutput, 0);
    @(posedge clk);
    #1 tb_en = 1'b1;
    @(negedge clk);
    chk({tag, "_c3_rdy"}, inputReady, 0);
    chk({tag, "_c3_bus"}, data_bus, PROBE);
  endtask

  task automatic write_txn(input string tag, input logic [15:0] a, input logic [15:0] d);
    writeM = 1'b1; address = a; tb_val = d;
    tick;
    writeM = 1'b0; tb_val = PROBE; address = 16'hFFFF;
    tick;
    chk({tag, "_c1_ack"}, ackOutput, 0);
    tick;
    chk({tag, "_c2_ack"}, ackOutput, 1);
    chk({tag, "_c2_rdy"}, inputReady, 0);
    chk({tag, "_c2_bus"}, data_bus, PROBE);
    tick;
    chk({tag, "_c3_ack"}, ackOutput, 0);
    tick;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy", inputReady, 0);
    chk("rst_ack", ackOutput, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_bus", data_bus, PROBE);
    reset = 1'b0;

    preload(16'h0010, 16'hBEEF);
    preload(16'h0030, 16'h1111);
    preload(16'h0040, 16'h4040);

    read_txn("rd10", 16'h0010, 16'h0010, 16'hBEEF, 0); tick;

    write_txn("wr20", 16'h0020, 16'h1234);
    read_txn("rd20", 16'h0020, 16'h0020, 16'h1234, 0); tick;

    // Upper address bits wrap; address change after acceptance is ignored.
    read_txn("wrap", 16'h0110, 16'h0000, 16'hBEEF, 0); tick;

    // Preload strobe while a request is present or busy must be ignored.
    init_we = 1'b1; init_addr = 16'h0040; init_data = 16'hDEAD;
    read_txn("rd_initblk", 16'h0010, 16'h0010, 16'hBEEF, 0);
    init_we = 1'b0; tick;
    read_txn("rd40", 16'h0040, 16'h0040, 16'h4040, 0); tick;

    // Held request gives exactly one pulse until it drops.
    read_txn("hold", 16'h0010, 16'h0010, 16'hBEEF, 1);
    pulses = 0;
    repeat (7) begin
      tick;
      if (inputReady) pulses++;
    end
    chk("hold_extra_pulses", pulses, 0);
    chk("hold_bus", data_bus, PROBE);
    readM = 1'b0; tick;
    read_txn("rearm", 16'h0020, 16'h0020, 16'h1234, 0); tick;

    // Both requests: read wins, error flag sticks until reset.
    writeM = 1'b1;
    read_txn("both", 16'h0010, 16'h0010, 16'hBEEF, 0);
    chk("both_err", proto_err, 1); tick;
    read_txn("after_both", 16'h0010, 16'h0010, 16'hBEEF, 0);
    chk("err_sticky", proto_err, 1); tick;
    reset = 1'b1;
    #1 chk("err_cleared", proto_err, 0);
    tick; reset = 1'b0;

    // Reset in the middle of a read wait.
    readM = 1'b1; address = 16'h0010;
    tick;
    readM = 1'b0;
    tick;
    reset = 1'b1;
    #1 chk("rstrd_rdy", inputReady, 0);
    chk("rstrd_bus", data_bus, PROBE);
    tick; tick; reset = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick;
      if (inputReady) pulses++;
    end
    chk("rstrd_no_pulse", pulses, 0);
    read_txn("rstrd_after", 16'h0010, 16'h0010, 16'hBEEF, 0); tick;

    // Reset during write wait drops the write.
    writeM = 1'b1; address = 16'h0030; tb_val = 16'h7777;
    tick;
    writeM = 1'b0; tb_val = PROBE;
    tick;
    reset = 1'b1;
    #1 chk("rstwr_ack", ackOutput, 0);
    tick; reset = 1'b0;
    pulses = 0;
    repeat (3) begin
      tick;
      if (ackOutput) pulses++;
    end
    chk("rstwr_no_ack", pulses, 0);
    read_txn("rstwr_kept", 16'h0030, 16'h0030, 16'h1111, 0); tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
